// File: rtl/mat_mult_nxn_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_nxn_fsm
// Description : N x N matrix multiplier, C = A * B. N*N parallel MAC lanes
//               are stepped over the inner index k by a small FSM, so one
//               operation takes N MAC edges plus one output edge.
//               Operands are signed or unsigned per operation.
// Ports       : clk, reset (async, active-high)
//               start        - request, honoured only in IDLE
//               signed_mode  - 1: two's-complement operands, 0: unsigned
//               a_flat/b_flat- element (i,j) at [(i*N+j)*DW +: DW]
//               c_flat       - registered result, [(i*N+j)*ACCW +: ACCW]
//               busy         - operation in flight
//               done         - one-cycle pulse when c_flat is updated
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_nxn_fsm #(
  parameter int N    = 2,
  parameter int DW   = 16,
  parameter int ACCW = (N > 1) ? 2*DW + $clog2(N) : 2*DW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [N*N*DW-1:0]     a_flat,
  input  logic [N*N*DW-1:0]     b_flat,
  output logic [N*N*ACCW-1:0]   c_flat,
  output logic                  busy,
  output logic                  done
);

  localparam int            KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [KW-1:0]      k_q;
  logic               busy_q, done_q, sm_q;
  logic [N*N*DW-1:0]  a_q, b_q;
  logic               load_en, mac_en, out_en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the spare encoding falls back to IDLE
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_MAC : S_IDLE;
      S_MAC:   state_d = (k_q == K_LAST) ? S_OUT : S_MAC;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    load_en = (state_q == S_IDLE) && start;
    mac_en  = (state_q == S_MAC);
    out_en  = (state_q == S_OUT);
  end

  // Operand capture, inner-index counter and handshake flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      k_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_en;
      if (load_en) begin
        a_q    <= a_flat;
        b_q    <= b_flat;
        sm_q   <= signed_mode;
        k_q    <= '0;
        busy_q <= 1'b1;
      end
      if (mac_en) begin
        k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
      if (out_en) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // One MAC lane per result element
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0]   a_el, b_el;
      logic [ACCW-1:0] a_ext, b_ext, prod;
      logic [ACCW-1:0] acc_q, c_q;

      // Pick A[i][k] and B[k][j] for the current k
      always_comb begin
        a_el = '0;
        b_el = '0;
        for (int kk = 0; kk < N; kk++) begin
          if (k_q == kk[KW-1:0]) begin
            a_el = a_q[(gi*N + kk)*DW +: DW];
            b_el = b_q[(kk*N + gj)*DW +: DW];
          end
        end
      end

      // Full-width product: truncation to ACCW is exact for both modes
      // because ACCW holds the whole sum without overflow.
      assign a_ext = sm_q ? {{(ACCW-DW){a_el[DW-1]}}, a_el} : {{(ACCW-DW){1'b0}}, a_el};
      assign b_ext = sm_q ? {{(ACCW-DW){b_el[DW-1]}}, b_el} : {{(ACCW-DW){1'b0}}, b_el};
      assign prod  = a_ext * b_ext;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_q <= '0;
          c_q   <= '0;
        end else begin
          if (load_en) acc_q <= '0;
          if (mac_en)  acc_q <= acc_q + prod;
          if (out_en)  c_q   <= acc_q;
        end
      end

      assign c_flat[(gi*N + gj)*ACCW +: ACCW] = c_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_nxn_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_mult_nxn_fsm
// Description : Self-checking bench for mat_mult_nxn_fsm at N=2 and N=3,
//               using an arithmetic reference model of C = A * B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_mult_nxn_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // N = 2 instance
  logic         start2 = 1'b0, sm2 = 1'b0;
  logic [63:0]  a2 = '0, b2 = '0;
  logic [131:0] c2;
  logic         busy2, done2;

  // N = 3 instance
  logic         start3 = 1'b0, sm3 = 1'b0;
  logic [143:0] a3 = '0, b3 = '0;
  logic [305:0] c3;
  logic         busy3, done3;

  int ntests = 0;
  int nfail  = 0;

  mat_mult_nxn_fsm #(.N(2), .DW(16)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
    .a_flat(a2), .b_flat(b2), .c_flat(c2), .busy(busy2), .done(done2));

  mat_mult_nxn_fsm #(.N(3), .DW(16)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .signed_mode(sm3),
    .a_flat(a3), .b_flat(b3), .c_flat(c3), .busy(busy3), .done(done3));

  // Reference: dot product of row i of A and column j of B in 64-bit arithmetic
  function automatic longint ref_elem(input logic [143:0] a, input logic [143:0] b,
                                      input logic sm, input int n, input int i, input int j);
    longint s, x, y;
    logic [15:0] ae, be;
    s = 0;
    for (int k = 0; k < n; k++) begin
      ae = a[(i*n + k)*16 +: 16];
      be = b[(k*n + j)*16 +: 16];
      x = sm ? {{48{ae[15]}}, ae} : {48'b0, ae};
      y = sm ? {{48{be[15]}}, be} : {48'b0, be};
      s += x * y;
    end
    return s;
  endfunction

  function automatic logic [131:0] model2(input logic [63:0] a, input logic [63:0] b, input logic sm);
    logic [131:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = ref_elem({80'b0, a}, {80'b0, b}, sm, 2, i, j);
        r[(i*2 + j)*33 +: 33] = s[32:0];
      end
    return r;
  endfunction

  function automatic logic [305:0] model3(input logic [143:0] a, input logic [143:0] b, input logic sm);
    logic [305:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = ref_elem(a, b, sm, 3, i, j);
        r[(i*3 + j)*34 +: 34] = s[33:0];
      end
    return r;
  endfunction

  function automatic logic rbit();
    return ($urandom & 32'd1) != 0;
  endfunction

  // One N=2 operation: latency, busy window, result, done pulse width
  task automatic op2(input logic [63:0] a, input logic [63:0] b, input logic sm,
                     input bit scr, input bit has_exp, input logic [131:0] exp_c,
                     input string nm);
    int cyc;
    bit busy_ok;
    logic [131:0] exp_m;
    exp_m = model2(a, b, sm);
    @(negedge clk);
    a2 = a; b2 = b; sm2 = sm; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0; busy_ok = 1'b1;
    while (done2 !== 1'b1 && cyc < 20) begin
      if (busy2 !== 1'b1) busy_ok = 1'b0;
      if (scr) begin
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; sm2 = ~sm2;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ntests++;
    if (cyc != 3) begin nfail++; $display("FAIL %s latency: got %0d cycles, expected 3", nm, cyc); end
    ntests++;
    if (!busy_ok || busy2 !== 1'b0) begin nfail++; $display("FAIL %s busy: window ok=%0b, busy at done=%b, expected 1/0", nm, busy_ok, busy2); end
    ntests++;
    if (c2 !== exp_m) begin nfail++; $display("FAIL %s result: got %h expected %h", nm, c2, exp_m); end
    if (has_exp) begin
      ntests++;
      if (c2 !== exp_c) begin nfail++; $display("FAIL %s constant: got %h expected %h", nm, c2, exp_c); end
    end
    @(posedge clk); #1;
    ntests++;
    if (done2 !== 1'b0) begin nfail++; $display("FAIL %s done width: got done=%b expected 0", nm, done2); end
  endtask

  task automatic op3(input logic [143:0] a, input logic [143:0] b, input logic sm,
                     input bit has_exp, input logic [305:0] exp_c, input string nm);
    int cyc;
    logic [305:0] exp_m;
    exp_m = model3(a, b, sm);
    @(negedge clk);
    a3 = a; b3 = b; sm3 = sm; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    a3 = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    cyc = 0;
    while (done3 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    ntests++;
    if (cyc != 4) begin nfail++; $display("FAIL %s latency: got %0d cycles, expected 4", nm, cyc); end
    ntests++;
    if (c3 !== exp_m) begin nfail++; $display("FAIL %s result: got %h expected %h", nm, c3, exp_m); end
    if (has_exp) begin
      ntests++;
      if (c3 !== exp_c) begin nfail++; $display("FAIL %s constant: got %h expected %h", nm, c3, exp_c); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    ntests++;
    if (c2 !== '0 || busy2 !== 1'b0 || done2 !== 1'b0)
      begin nfail++; $display("FAIL reset2: c=%h busy=%b done=%b, expected all 0", c2, busy2, done2); end
    ntests++;
    if (c3 !== '0 || busy3 !== 1'b0 || done3 !== 1'b0)
      begin nfail++; $display("FAIL reset3: c=%h busy=%b done=%b, expected all 0", c3, busy3, done3); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_directed2();
    op2({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0, 1'b1,
        {33'd50, 33'd43, 33'd22, 33'd19}, "basic2x2");
    op2({4{16'h8000}}, {4{16'h8000}}, 1'b1, 1'b0, 1'b1, {4{33'h0_8000_0000}}, "min_signed");
    op2({4{16'h8000}}, {4{16'h8000}}, 1'b0, 1'b0, 1'b1, {4{33'h0_8000_0000}}, "8000_unsigned");
    op2({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0, 1'b0, 1'b1, {4{33'h1_FFFC_0002}}, "max_unsigned");
    op2({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b1, 1'b0, 1'b1, {4{33'd2}}, "minus1_signed");
  endtask

  task automatic test_random2();
    for (int r = 0; r < 8; r++)
      op2({$urandom, $urandom}, {$urandom, $urandom}, rbit(), r[0], 1'b0, '0, "random2");
  endtask

  task automatic test_n3();
    int bv[9] = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    logic [143:0] ident, bpk;
    logic [305:0] bexp;
    longint t;
    ident = '0; bpk = '0; bexp = '0;
    for (int e = 0; e < 9; e++) begin
      t = bv[e];
      bpk[e*16 +: 16]  = t[15:0];
      bexp[e*34 +: 34] = t[33:0];
    end
    ident[0*16 +: 16] = 16'd1;
    ident[4*16 +: 16] = 16'd1;
    ident[8*16 +: 16] = 16'd1;
    op3(ident, bpk, 1'b1, 1'b1, bexp, "n3_I_times_B");
    op3(bpk, ident, 1'b1, 1'b1, bexp, "n3_A_times_I");
    for (int r = 0; r < 4; r++)
      op3({$urandom, $urandom, $urandom, $urandom, 16'($urandom)},
          {$urandom, $urandom, $urandom, $urandom, 16'($urandom)}, rbit(), 1'b0, '0, "random3");
  endtask

  task automatic test_back_to_back();
    logic [63:0] as[2], bs[2];
    logic        sms[2];
    int cur, cyc;
    for (int p = 0; p < 2; p++) begin
      as[p] = {$urandom, $urandom}; bs[p] = {$urandom, $urandom}; sms[p] = rbit();
    end
    @(negedge clk);
    a2 = as[0]; b2 = bs[0]; sm2 = sms[0]; start2 = 1'b1;
    @(posedge clk); #1;
    cur = 0;
    a2 = as[1]; b2 = bs[1]; sm2 = sms[1];
    for (int r = 0; r < 4; r++) begin
      cyc = 0;
      while (done2 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      ntests++;
      if (cyc != 3) begin nfail++; $display("FAIL b2b period: got %0d cycles, expected 3", cyc); end
      ntests++;
      if (c2 !== model2(as[cur], bs[cur], sms[cur]))
        begin nfail++; $display("FAIL b2b result: got %h expected %h", c2, model2(as[cur], bs[cur], sms[cur])); end
      @(posedge clk); #1;
      ntests++;
      if (done2 !== 1'b0 || busy2 !== 1'b1)
        begin nfail++; $display("FAIL b2b capture: done=%b busy=%b, expected 0/1", done2, busy2); end
      cur = cur ^ 1;
      a2 = as[cur ^ 1]; b2 = bs[cur ^ 1]; sm2 = sms[cur ^ 1];
    end
    start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    ntests++;
    if (c2 !== model2(as[cur], bs[cur], sms[cur]))
      begin nfail++; $display("FAIL b2b drain: got %h expected %h", c2, model2(as[cur], bs[cur], sms[cur])); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic [63:0]  a, b;
    logic         sm;
    logic [131:0] prev;
    int cyc, extra;
    bit held;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sm = rbit();
    prev = c2;
    @(negedge clk);
    a2 = a; b2 = b; sm2 = sm; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    held = 1'b1;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 20) begin
      if (c2 !== prev) held = 1'b0;
      start2 = (cyc == 1);
      a2 = ~a; b2 = ~b; sm2 = ~sm;
      @(posedge clk); #1;
      cyc++;
    end
    start2 = 1'b0;
    ntests++;
    if (held !== 1'b1) begin nfail++; $display("FAIL ignore c_hold: c_flat changed before done (was %h)", prev); end
    ntests++;
    if (cyc != 3) begin nfail++; $display("FAIL ignore latency: got %0d expected 3", cyc); end
    ntests++;
    if (c2 !== model2(a, b, sm)) begin nfail++; $display("FAIL ignore result: got %h expected %h", c2, model2(a, b, sm)); end
    extra = 0;
    prev = c2;
    repeat (6) begin
      @(posedge clk); #1;
      if (done2 === 1'b1 || busy2 === 1'b1 || c2 !== prev) extra++;
    end
    ntests++;
    if (extra != 0) begin nfail++; $display("FAIL ignore queued: %0d active cycles after done, expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clk);
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; sm2 = rbit(); start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    ntests++;
    if (c2 !== '0 || busy2 !== 1'b0 || done2 !== 1'b0)
      begin nfail++; $display("FAIL reset_mid: c=%h busy=%b done=%b, expected all 0", c2, busy2, done2); end
    @(negedge clk); reset = 1'b0;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done2 !== 1'b0 || busy2 !== 1'b0) stray++;
    end
    ntests++;
    if (stray != 0) begin nfail++; $display("FAIL reset_mid stray: %0d active cycles, expected 0", stray); end
    op2({$urandom, $urandom}, {$urandom, $urandom}, rbit(), 1'b0, 1'b0, '0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed2();
    test_random2();
    test_n3();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
